// File: rtl/axi_wr_cmd_queue.sv
// rtl/axi_wr_cmd_queue.sv - write request FIFO feeding a write-only AXI master, one transaction at a time
module axi_wr_cmd_queue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     i_clk,
   input  logic                     i_resetn,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic [31:0]              i_req_addr,
   input  logic [31:0]              i_req_data,
   input  logic [3:0]               i_req_strb,
   output logic                     o_wr,
   output logic [31:0]              o_addr,
   output logic [31:0]              o_din,
   output logic [3:0]               o_strb,
   input  logic                     i_bvalid,
   input  logic                     i_bready,
   input  logic [1:0]               i_bresp,
   output logic                     o_resp_valid,
   output logic [1:0]               o_resp,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_busy,
   output logic [7:0]               o_err_count,
   output logic                     o_timeout,
   input  logic                     i_clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t          state, state_nxt;
   logic [67:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   wait_cnt;
   logic [67:0]     head;
   logic            push, pop, hs, expired;
   logic            done, done_err, done_to;
   logic [1:0]      done_resp;

   assign o_req_ready = (o_level != LVL_FULL);
   assign o_busy      = (state != ST_IDLE) || (o_level != '0);
   assign push        = i_req_valid && o_req_ready;
   // The head leaves the FIFO on the edge that takes ISSUE into WAIT_RESP
   assign pop         = (state == ST_ISSUE);
   assign head        = mem[rd_ptr];
   assign hs          = i_bvalid && i_bready;
   assign expired     = (wait_cnt == CNT_LAST);

   // FIFO storage: payload only, no reset needed
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= {i_req_addr, i_req_data, i_req_strb};
   end

   // FIFO pointers and occupancy; simultaneous push and pop cancel out
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   o_level <= o_level + 1'b1;
            2'b01:   o_level <= o_level - 1'b1;
            default: o_level <= o_level;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   // FSM next state; a handshake beats the timeout when both land together
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (o_level != '0) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (hs || expired) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Completion decode used by the registered outputs
   always_comb begin
      done      = (state == ST_WAIT) && (hs || expired);
      done_resp = hs ? i_bresp : 2'b10;
      done_err  = done && (done_resp != 2'b00);
      done_to   = done && !hs;
   end

   // Registered outputs, wait counter and error bookkeeping
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_wr         <= 1'b0;
         o_addr       <= '0;
         o_din        <= '0;
         o_strb       <= '0;
         o_resp_valid <= 1'b0;
         o_resp       <= '0;
         o_err_count  <= '0;
         o_timeout    <= 1'b0;
         wait_cnt     <= '0;
      end else begin
         o_wr         <= 1'b0;
         o_resp_valid <= 1'b0;
         if (state == ST_IDLE && o_level != '0) begin
            o_wr     <= 1'b1;
            o_addr   <= head[67:36];
            o_din    <= head[35:4];
            o_strb   <= head[3:0];
            wait_cnt <= '0;
         end
         if (state == ST_WAIT && !done) wait_cnt <= wait_cnt + 1'b1;
         if (done) begin
            o_resp_valid <= 1'b1;
            o_resp       <= done_resp;
         end
         // A clear that coincides with an error completion keeps that error
         if (i_clr_err) begin
            o_err_count <= done_err ? 8'd1 : 8'd0;
            o_timeout   <= done_to;
         end else begin
            if (done_err && o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
            if (done_to) o_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_wr_cmd_queue.sv
// tb/tb_axi_wr_cmd_queue.sv - directed self-checking bench for axi_wr_cmd_queue
module tb_axi_wr_cmd_queue;

   logic        i_clk = 1'b0;
   logic        i_resetn;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_addr, i_req_data;
   logic [3:0]  i_req_strb;
   logic        o_wr;
   logic [31:0] o_addr, o_din;
   logic [3:0]  o_strb;
   logic        i_bvalid, i_bready;
   logic [1:0]  i_bresp;
   logic        o_resp_valid;
   logic [1:0]  o_resp;
   logic [2:0]  o_level;
   logic        o_busy;
   logic [7:0]  o_err_count;
   logic        o_timeout;
   logic        i_clr_err;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int resp_cnt = 0;
   int overlap  = 0;
   bit outstanding = 1'b0;
   logic [31:0] addr_q[$];

   axi_wr_cmd_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
      .i_clk(i_clk), .i_resetn(i_resetn),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_strb(i_req_strb),
      .o_wr(o_wr), .o_addr(o_addr), .o_din(o_din), .o_strb(o_strb),
      .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bresp(i_bresp),
      .o_resp_valid(o_resp_valid), .o_resp(o_resp),
      .o_level(o_level), .o_busy(o_busy),
      .o_err_count(o_err_count), .o_timeout(o_timeout), .i_clr_err(i_clr_err)
   );

   always #5 i_clk = ~i_clk;

   // Record issued commands and completions away from the active edge
   always @(negedge i_clk) begin
      if (!i_resetn) outstanding = 1'b0;
      else begin
         if (o_wr) begin
            wr_cnt++;
            addr_q.push_back(o_addr);
            if (outstanding) overlap++;
            outstanding = 1'b1;
         end
         if (o_resp_valid) begin
            resp_cnt++;
            outstanding = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sync();
      @(posedge i_clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit acc = 1'b0;
      i_req_valid = 1'b1;
      i_req_addr  = a;
      i_req_data  = d;
      i_req_strb  = s;
      for (int n = 0; n < 40; n++) begin
         @(negedge i_clk);
         if (o_req_ready) begin
            @(posedge i_clk);
            #1;
            acc = 1'b1;
            break;
         end
      end
      i_req_valid = 1'b0;
      if (!acc) check("push_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_wr(output int n);
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge i_clk);
         if (o_wr) begin
            n = k;
            break;
         end
      end
      if (n == 0) check("wr_seen", 32'd0, 32'd1);
   endtask

   // Handshake lands on the (k+1)-th rising edge from now
   task automatic send_b(input int k, input logic [1:0] r);
      repeat (k) @(posedge i_clk);
      #1;
      i_bvalid = 1'b1;
      i_bready = 1'b1;
      i_bresp  = r;
      @(posedge i_clk);
      #1;
      i_bvalid = 1'b0;
      i_bready = 1'b0;
      i_bresp  = 2'b00;
   endtask

   initial begin
      int n;
      int base_wr, base_resp;
      logic [31:0] exp_q [6];
      i_resetn = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_req_data = '0;
      i_req_strb = '0; i_bvalid = 1'b0; i_bready = 1'b0; i_bresp = '0; i_clr_err = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_wr", 32'(o_wr), 0);
      check("rst_ready", 32'(o_req_ready), 1);
      check("rst_level", 32'(o_level), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_err", 32'(o_err_count), 0);
      check("rst_timeout", 32'(o_timeout), 0);
      check("rst_resp_valid", 32'(o_resp_valid), 0);
      sync();
      i_resetn = 1'b1;
      sync();

      // Single write with latency
      push_one(32'h3, 32'hDEADBEEF, 4'hF);
      @(negedge i_clk);
      check("lat_e0_wr", 32'(o_wr), 0);
      check("lat_e0_level", 32'(o_level), 1);
      @(negedge i_clk);
      check("single_wr", 32'(o_wr), 1);
      check("single_addr", o_addr, 32'h3);
      check("single_din", o_din, 32'hDEADBEEF);
      check("single_strb", 32'(o_strb), 32'hF);
      send_b(1, 2'b00);
      @(negedge i_clk);
      check("single_resp_valid", 32'(o_resp_valid), 1);
      check("single_resp", 32'(o_resp), 0);
      check("single_err", 32'(o_err_count), 0);
      @(negedge i_clk);
      check("single_resp_pulse", 32'(o_resp_valid), 0);
      check("single_busy", 32'(o_busy), 0);
      check("single_wr_count", 32'(wr_cnt), 1);

      // Error completion and clear
      sync();
      push_one(32'h20, 32'h12345678, 4'h3);
      wait_wr(n);
      check("err_addr", o_addr, 32'h20);
      send_b(1, 2'b11);
      @(negedge i_clk);
      check("err_resp", 32'(o_resp), 32'h3);
      check("err_count1", 32'(o_err_count), 1);
      sync();
      i_clr_err = 1'b1;
      sync();
      i_clr_err = 1'b0;
      @(negedge i_clk);
      check("err_cleared", 32'(o_err_count), 0);

      // Timeout with a second request queued behind it
      sync();
      push_one(32'h40, 32'h1, 4'h1);
      push_one(32'h44, 32'h2, 4'h2);
      wait_wr(n);
      check("to_first_addr", o_addr, 32'h40);
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge i_clk);
         if (o_resp_valid) begin
            n = k;
            break;
         end
      end
      check("to_cycles", 32'(n), 9);
      check("to_resp", 32'(o_resp), 32'h2);
      check("to_flag", 32'(o_timeout), 1);
      check("to_err", 32'(o_err_count), 1);
      check("to_level", 32'(o_level), 1);
      wait_wr(n);
      check("to_next_lat", 32'(n), 1);
      check("to_next_addr", o_addr, 32'h44);
      send_b(1, 2'b00);
      @(negedge i_clk);
      check("to_next_resp", 32'(o_resp), 0);
      check("to_sticky", 32'(o_timeout), 1);

      // Handshake on the last wait cycle wins over the timeout
      sync();
      i_clr_err = 1'b1;
      sync();
      i_clr_err = 1'b0;
      @(negedge i_clk);
      check("clr_timeout", 32'(o_timeout), 0);
      sync();
      push_one(32'h50, 32'h5, 4'hF);
      wait_wr(n);
      send_b(8, 2'b00);
      @(negedge i_clk);
      check("edge_resp_valid", 32'(o_resp_valid), 1);
      check("edge_resp", 32'(o_resp), 0);
      check("edge_timeout", 32'(o_timeout), 0);
      check("edge_err", 32'(o_err_count), 0);

      // Clear coinciding with a timeout completion keeps that one error
      sync();
      push_one(32'h54, 32'h6, 4'hF);
      wait_wr(n);
      send_b(1, 2'b10);
      @(negedge i_clk);
      check("slverr_count", 32'(o_err_count), 1);
      sync();
      push_one(32'h58, 32'h7, 4'hF);
      wait_wr(n);
      repeat (8) @(posedge i_clk);
      #1;
      i_clr_err = 1'b1;
      sync();
      i_clr_err = 1'b0;
      @(negedge i_clk);
      check("coin_resp_valid", 32'(o_resp_valid), 1);
      check("coin_resp", 32'(o_resp), 32'h2);
      check("coin_err", 32'(o_err_count), 1);
      check("coin_timeout", 32'(o_timeout), 1);

      // Fill beyond DEPTH, then drain in order
      @(negedge i_clk);
      check("fill_idle", 32'(o_busy), 0);
      addr_q.delete();
      base_wr = wr_cnt;
      sync();
      for (int i = 0; i < 5; i++) push_one(32'(i), 32'hA000_0000 + 32'(i), 4'hF);
      check("fill_level", 32'(o_level), 4);
      check("fill_ready", 32'(o_req_ready), 0);
      check("fill_busy", 32'(o_busy), 1);
      check("fill_issued", 32'(wr_cnt - base_wr), 1);
      i_req_valid = 1'b1;
      i_req_addr  = 32'h5;
      i_req_data  = 32'hA000_0005;
      i_req_strb  = 4'hF;
      repeat (3) @(negedge i_clk);
      check("full_push_ignored", 32'(o_level), 4);
      send_b(1, 2'b00);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge i_clk);
         if (o_req_ready) begin
            n = k;
            break;
         end
      end
      sync();
      i_req_valid = 1'b0;
      check("refill_ready", 32'(n != 0), 1);
      check("refill_level", 32'(o_level), 4);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) wait_wr(n);
         send_b(1, 2'b00);
      end
      @(negedge i_clk);
      check("drain_busy", 32'(o_busy), 0);
      check("drain_count", 32'(addr_q.size()), 6);
      for (int i = 0; i < 6; i++) exp_q[i] = 32'(i);
      for (int i = 0; i < 6 && i < addr_q.size(); i++) check("order_addr", addr_q[i], exp_q[i]);
      check("no_overlap", 32'(overlap), 0);

      // Reset in the middle of a transaction with two queued
      sync();
      push_one(32'h60, 32'h0, 4'hF);
      push_one(32'h61, 32'h0, 4'hF);
      push_one(32'h62, 32'h0, 4'hF);
      @(negedge i_clk);
      check("pre_rst_level", 32'(o_level), 2);
      #2;
      i_resetn = 1'b0;
      #1;
      check("arst_level", 32'(o_level), 0);
      check("arst_ready", 32'(o_req_ready), 1);
      check("arst_busy", 32'(o_busy), 0);
      check("arst_err", 32'(o_err_count), 0);
      check("arst_timeout", 32'(o_timeout), 0);
      check("arst_addr", o_addr, 0);
      sync();
      i_resetn = 1'b1;
      base_wr   = wr_cnt;
      base_resp = resp_cnt;
      repeat (20) @(negedge i_clk);
      check("post_rst_wr", 32'(wr_cnt - base_wr), 0);
      check("post_rst_resp", 32'(resp_cnt - base_resp), 0);
      check("post_rst_level", 32'(o_level), 0);
      sync();
      push_one(32'h70, 32'h77, 4'h1);
      wait_wr(n);
      check("post_rst_addr", o_addr, 32'h70);
      send_b(1, 2'b00);
      @(negedge i_clk);
      check("post_rst_resp_valid", 32'(o_resp_valid), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
